// File: rtl/mult8_pkg.sv
// Shared definitions for the sequential 8x8 nibble multiplier: FSM states,
// shift codes and the step-to-shift mapping.
package mult8_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] SH_NONE   = 2'b00;
   localparam logic [1:0] SH_4      = 2'b01;
   localparam logic [1:0] SH_8      = 2'b10;
   localparam logic [1:0] LAST_STEP = 2'd3;

   // Step 0 is lo*lo, steps 1/2 are the cross terms, step 3 is hi*hi.
   function automatic logic [1:0] shift_of(input logic [1:0] step);
      case (step)
         2'd0:    return SH_NONE;
         2'd3:    return SH_8;
         default: return SH_4;
      endcase
   endfunction

endpackage

// File: rtl/nibble_mul.sv
// 4x4 -> 8-bit unsigned combinational multiply used once per CALC step.
module nibble_mul (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_p
);

   assign o_p = {4'b0, i_a} * {4'b0, i_b};

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 multiplier: one nibble partial product per cycle over four
// CALC cycles. Optional MULT8_ZERO_SKIP_EN short-circuits zero operands.
module mult8_seq_ctrl
   import mult8_pkg::*;
(
   input  logic        clk,
   input  logic        reset_a,
   input  logic        start,
   input  logic [7:0]  data_a,
   input  logic [7:0]  data_b,
   output logic        busy,
   output logic        done,
   output logic [15:0] product,
   output logic [1:0]  shift_sel
);

   state_t      r_state;
   logic [1:0]  r_count;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [15:0] r_acc;
   logic        r_busy;
   logic        r_done;
`ifdef MULT8_ZERO_SKIP_EN
   logic        r_skip;
`endif

   logic [3:0]  w_nib_a;
   logic [3:0]  w_nib_b;
   logic [7:0]  w_pp;
   logic [1:0]  w_shift;
   logic [15:0] w_term;

   // count[1] picks the a nibble, count[0] the b nibble
   assign w_nib_a = r_count[1] ? r_a[7:4] : r_a[3:0];
   assign w_nib_b = r_count[0] ? r_b[7:4] : r_b[3:0];
   assign w_shift = shift_of(r_count);
   assign w_term  = {8'b0, w_pp} << {w_shift, 2'b00};

   nibble_mul u_nmul (
      .i_a (w_nib_a),
      .i_b (w_nib_b),
      .o_p (w_pp)
   );

   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         r_state <= IDLE;
         r_count <= 2'd0;
         r_a     <= 8'd0;
         r_b     <= 8'd0;
         r_acc   <= 16'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef MULT8_ZERO_SKIP_EN
         r_skip  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
`ifdef MULT8_ZERO_SKIP_EN
               // zero operand: spend one DONE cycle with done low, then pulse
               if (r_skip) begin
                  r_skip <= 1'b0;
                  r_done <= 1'b1;
               end else
`endif
               if (start) begin
                  r_a     <= data_a;
                  r_b     <= data_b;
                  r_acc   <= 16'd0;
                  r_count <= 2'd0;
`ifdef MULT8_ZERO_SKIP_EN
                  if (data_a == 8'd0 || data_b == 8'd0) begin
                     r_state <= DONE;
                     r_skip  <= 1'b1;
                  end else
`endif
                  begin
                     r_state <= CALC;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            CALC: begin
               r_acc   <= r_acc + w_term;
               r_count <= r_count + 2'd1;
               if (r_count == LAST_STEP) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign product   = r_acc;
   assign shift_sel = (r_state == CALC) ? w_shift : SH_NONE;

endmodule

// File: doc/mult8_seq_ctrl.md
MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_a  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 data_a  input  8  unsigned multiplicand, captured when start is accepted.
REQ-006 data_b  input  8  unsigned multiplier, captured when start is accepted.
REQ-007 busy  output  1  high while state = CALC.
REQ-008 done  output  1  single-cycle pulse; product valid.
REQ-009 product  output  16  accumulated result; held until next accepted start.
REQ-010 shift_sel  output  2  current shift code, for debug and observation: 00 none, 01 <<4, 10 <<8.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-012 IDLE, start=1 -> latch data_a/data_b, clear accumulator, count=0, go CALC.
REQ-013 CALC SHALL take 4 cycles, one partial product per cycle, in this fixed order:
  - count 0: a[3:0]*b[3:0], shift 00
  - count 1: a[3:0]*b[7:4], shift 01
  - count 2: a[7:4]*b[3:0], shift 01
  - count 3: a[7:4]*b[7:4], shift 10
REQ-014 Each CALC cycle SHALL add the 8-bit nibble product, zero-extended to 16 bits and shifted, to the 16-bit accumulator (no overflow possible).
REQ-015 After count 3 the FSM SHALL go to DONE.
REQ-016 Latency: with start sampled at edge N, accumulation occurs at edges N+1..N+4, and done=1 between edges N+4 and N+5.
REQ-017 DONE, start=1 -> accept the new operation directly (back-to-back) and go CALC; DONE, start=0 -> go IDLE.
REQ-018 start while in CALC SHALL be ignored; operands and accumulator are not disturbed.
REQ-019 product SHALL equal the accumulator register and remain stable in IDLE/DONE until the next accepted start clears it.
REQ-020 shift_sel SHALL be 00 outside CALC.

Reset
REQ-021 reset_a=1 SHALL immediately force state=IDLE, count=0, operands=0, accumulator/product=0, busy=0, done=0, shift_sel=00.
REQ-022 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after deassertion is accepted normally.

Configuration
REQ-023 Macro MULT8_ZERO_SKIP_EN defined: an accepted start with data_a==0 or data_b==0 SHALL go directly to DONE with product=0, so done pulses between edges N+1 and N+2 and busy never rises.
REQ-024 Macro MULT8_ZERO_SKIP_EN undefined: all operands SHALL take the full 4-cycle CALC path.

Structure
REQ-025 Shared package mult8_pkg SHALL hold: state encoding (IDLE, CALC, DONE), shift codes SH_NONE=2'b00, SH_4=2'b01, SH_8=2'b10, and constant LAST_STEP=2'd3.
REQ-026 One sub-module nibble_mul (4x4 -> 8-bit combinational unsigned multiply) SHALL be instantiated.
REQ-027 Nibble selection, shifting, FSM and accumulator SHALL reside in mult8_seq_ctrl.

Verification
REQ-028 Full-scale: start with a=0xFF, b=0xFF at edge N -> product=0xFE01 with done=1 after edge N+4; busy high for exactly 4 cycles.
REQ-029 Typical operands: a=0x12, b=0x34 -> product=0x03A8; shift_sel sequence during CALC is 00, 01, 01, 10.
REQ-030 Busy protection: start pulsed with a=0x01, b=0x01 during CALC of 0x0F*0x10 -> result 0x00F0; the second request is ignored.
REQ-031 Back-to-back: start held high through DONE with a=0x80, b=0x02 -> second CALC begins with no IDLE cycle; product=0x0100.
REQ-032 Reset mid-operation: reset_a pulsed at count 2 -> outputs all 0 asynchronously, no done pulse; next op 0x03*0x05 -> 0x000F.
REQ-033 Zero operand: a=0x00, b=0x7F -> with MULT8_ZERO_SKIP_EN, done after 1 cycle and product=0; without it, done after 4 cycles and product=0.
